// File: rtl/dl_pkg.sv
// Shared types and helpers for the deadlock-detect network (collector and detect units).
package dl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ARM    = 3'd2,
        REPORT = 3'd3,
        HALT   = 3'd4
    } dl_state_e;

    // Width of a process index; never narrower than one bit.
    function automatic int unsigned proc_id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dl_lowest_onehot.sv
// Combinational lowest-set-bit finder: one-hot mask and binary index of the lowest set bit.
module dl_lowest_onehot
    import dl_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0]            i_vec,
    output logic [W-1:0]            o_onehot,
    output logic [proc_id_w(W)-1:0] o_idx
);

    localparam int unsigned IDX_W = proc_id_w(W);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dl_report_collector.sv
// Deadlock report collector: elects an origin, flushes tokens, confirms a persistent
// cycle, then latches dl_detect_out and streams the deadlocked process IDs.
module dl_report_collector
    import dl_pkg::*;
#(
    parameter int unsigned PROC_NUM       = 5,
    parameter int unsigned CLEAR_CYCLES   = 2,
    parameter int unsigned CONFIRM_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [PROC_NUM-1:0]           dl_in_vec,
    output logic                          dl_detect_out,
    output logic [PROC_NUM-1:0]           origin,
    output logic                          token_clear,
    output logic                          report_valid,
    input  logic                          report_ready,
    output logic [proc_id_w(PROC_NUM)-1:0] report_proc_id,
    output logic                          report_last
);

    localparam int unsigned ID_W  = proc_id_w(PROC_NUM);
    localparam int unsigned CNT_W = $clog2(max_u(CLEAR_CYCLES, CONFIRM_CYCLES)) + 1;

    dl_state_e           r_state, w_state_n;
    logic [PROC_NUM-1:0] r_origin, w_origin_n;
    logic [PROC_NUM-1:0] r_snap, w_snap_n;
    logic [CNT_W-1:0]    r_clr_cnt, w_clr_cnt_n;
    logic [CNT_W-1:0]    r_cf_cnt, w_cf_cnt_n;
    logic                r_detect, w_detect_n;
    logic                r_token_clear, w_token_clear_n;
    logic                r_valid, w_valid_n;
    logic [ID_W-1:0]     r_proc_id, w_proc_id_n;
    logic                r_last, w_last_n;

    logic [PROC_NUM-1:0] w_src;
    logic [PROC_NUM-1:0] w_sel_onehot;
    logic [ID_W-1:0]     w_sel_idx;
    logic [PROC_NUM-1:0] w_cur_onehot;
    logic                w_src_any;
    logic                w_src_single;
    logic                w_hit;
    logic                w_accept;

    assign w_cur_onehot = PROC_NUM'(1) << r_proc_id;
    assign w_hit        = |(dl_in_vec & r_origin);
    assign w_accept     = r_valid & report_ready;

    // Finder input: election in IDLE, first beat in ARM, next remaining beat in REPORT.
    always_comb begin
        w_src = '0;
        case (r_state)
            IDLE:    w_src = dl_in_vec;
            ARM:     w_src = dl_in_vec | r_origin;
            REPORT:  w_src = r_snap & ~w_cur_onehot;
            default: w_src = '0;
        endcase
    end

    dl_lowest_onehot #(.W(PROC_NUM)) u_lowest (
        .i_vec    (w_src),
        .o_onehot (w_sel_onehot),
        .o_idx    (w_sel_idx)
    );

    assign w_src_any    = |w_src;
    assign w_src_single = w_src_any && (w_src == w_sel_onehot);

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_origin      <= '0;
            r_snap        <= '0;
            r_clr_cnt     <= '0;
            r_cf_cnt      <= '0;
            r_detect      <= 1'b0;
            r_token_clear <= 1'b0;
            r_valid       <= 1'b0;
            r_proc_id     <= '0;
            r_last        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_origin      <= w_origin_n;
            r_snap        <= w_snap_n;
            r_clr_cnt     <= w_clr_cnt_n;
            r_cf_cnt      <= w_cf_cnt_n;
            r_detect      <= w_detect_n;
            r_token_clear <= w_token_clear_n;
            r_valid       <= w_valid_n;
            r_proc_id     <= w_proc_id_n;
            r_last        <= w_last_n;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (|dl_in_vec) w_state_n = CLEAR;
            CLEAR:   if (r_clr_cnt == '0) w_state_n = ARM;
            ARM: begin
                if (!w_hit)                                        w_state_n = IDLE;
                else if (r_cf_cnt == CNT_W'(CONFIRM_CYCLES - 1))   w_state_n = REPORT;
            end
            REPORT:  if (w_accept && !w_src_any) w_state_n = HALT;
            HALT:    w_state_n = HALT;
            default: w_state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, counters and snapshot.
    always_comb begin
        w_origin_n      = r_origin;
        w_snap_n        = r_snap;
        w_clr_cnt_n     = r_clr_cnt;
        w_cf_cnt_n      = r_cf_cnt;
        w_detect_n      = r_detect;
        w_token_clear_n = r_token_clear;
        w_valid_n       = r_valid;
        w_proc_id_n     = r_proc_id;
        w_last_n        = r_last;
        case (r_state)
            IDLE: begin
                w_origin_n      = '0;
                w_token_clear_n = 1'b0;
                if (|dl_in_vec) begin
                    w_origin_n      = w_sel_onehot;
                    w_token_clear_n = 1'b1;
                    w_clr_cnt_n     = CNT_W'(CLEAR_CYCLES - 1);
                end
            end
            CLEAR: begin
                if (r_clr_cnt == '0) begin
                    w_token_clear_n = 1'b0;
                    w_cf_cnt_n      = '0;
                end else begin
                    w_clr_cnt_n = r_clr_cnt - CNT_W'(1);
                end
            end
            ARM: begin
                if (!w_hit) begin
                    w_origin_n      = '0;
                    w_token_clear_n = 1'b1;
                end else if (r_cf_cnt == CNT_W'(CONFIRM_CYCLES - 1)) begin
                    w_snap_n    = w_src;
                    w_detect_n  = 1'b1;
                    w_valid_n   = 1'b1;
                    w_proc_id_n = w_sel_idx;
                    w_last_n    = w_src_single;
                end else begin
                    w_cf_cnt_n = r_cf_cnt + CNT_W'(1);
                end
            end
            REPORT: begin
                if (w_accept) begin
                    w_snap_n    = w_src;
                    w_valid_n   = w_src_any;
                    w_proc_id_n = w_sel_idx;
                    w_last_n    = w_src_single;
                end
            end
            HALT: begin
                w_valid_n       = 1'b0;
                w_token_clear_n = 1'b0;
                w_last_n        = 1'b0;
            end
            default: begin
                w_origin_n = '0;
            end
        endcase
    end

    assign dl_detect_out  = r_detect;
    assign origin         = r_origin;
    assign token_clear    = r_token_clear;
    assign report_valid   = r_valid;
    assign report_proc_id = r_proc_id;
    assign report_last    = r_last;

endmodule

// File: tb/tb_dl_report_collector.sv
// Self-checking bench for dl_report_collector with a queue of expected report beats.
module tb_dl_report_collector;

    localparam int unsigned PN   = 5;
    localparam int unsigned ID_W = 3;

    logic            clock;
    logic            reset;
    logic [PN-1:0]   dl_in_vec;
    logic            dl_detect_out;
    logic [PN-1:0]   origin;
    logic            token_clear;
    logic            report_valid;
    logic            report_ready;
    logic [ID_W-1:0] report_proc_id;
    logic            report_last;

    typedef struct {
        int id;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks;
    int    n_errors;

    dl_report_collector #(
        .PROC_NUM       (PN),
        .CLEAR_CYCLES   (2),
        .CONFIRM_CYCLES (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dl_in_vec      (dl_in_vec),
        .dl_detect_out  (dl_detect_out),
        .origin         (origin),
        .token_clear    (token_clear),
        .report_valid   (report_valid),
        .report_ready   (report_ready),
        .report_proc_id (report_proc_id),
        .report_last    (report_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected beats: every set bit of the snapshot, ascending, last on the highest.
    task automatic push_expected(input logic [PN-1:0] snap);
        int cnt;
        int k;
        cnt = $countones(snap);
        k   = 0;
        for (int i = 0; i < int'(PN); i++) begin
            if (snap[i]) begin
                k++;
                exp_q.push_back('{id: i, last: int'(k == cnt)});
            end
        end
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_detect"}, int'(dl_detect_out), 0);
        check({pfx, "_origin"}, int'(origin), 0);
        check({pfx, "_tclr"},   int'(token_clear), 0);
        check({pfx, "_valid"},  int'(report_valid), 0);
        check({pfx, "_id"},     int'(report_proc_id), 0);
        check({pfx, "_last"},   int'(report_last), 0);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        dl_in_vec    = '0;
        report_ready = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        check_quiet("rst");
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!report_valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_seen", int'(report_valid), 1);
    endtask

    // Drive report_ready from a pattern and score every accepted beat.
    task automatic collect(input int budget, input logic [15:0] pat);
        bit pend;
        bit done;
        int pid;
        int plast;
        pend  = 1'b0;
        done  = 1'b0;
        pid   = 0;
        plast = 0;
        for (int i = 0; i < budget && !done; i++) begin
            report_ready = pat[i % 16];
            if (report_valid) begin
                if (pend) begin
                    check("hold_id",   int'(report_proc_id), pid);
                    check("hold_last", int'(report_last), plast);
                end
                if (report_ready) begin
                    check("q_nonempty", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        beat_t b;
                        b = exp_q.pop_front();
                        check("beat_id",   int'(report_proc_id), b.id);
                        check("beat_last", int'(report_last), b.last);
                        if (exp_q.size() == 0) done = 1'b1;
                    end
                    pend = 1'b0;
                end else begin
                    pend  = 1'b1;
                    pid   = int'(report_proc_id);
                    plast = int'(report_last);
                end
            end
            tick();
        end
        check("report_done", int'(done), 1);
        check("valid_after_last", int'(report_valid), 0);
    endtask

    task automatic check_halt(input int exp_origin);
        dl_in_vec    = '0;
        report_ready = 1'b1;
        repeat (4) begin
            tick();
            check("halt_detect", int'(dl_detect_out), 1);
            check("halt_origin", int'(origin), exp_origin);
            check("halt_valid",  int'(report_valid), 0);
            check("halt_tclr",   int'(token_clear), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b0;
        dl_in_vec    = '0;
        report_ready = 1'b0;

        // Reset held with all requests high, then release.
        dl_in_vec = 5'b11111;
        repeat (3) tick();
        check_quiet("t1_hold");
        reset = 1'b1;
        tick();
        check("t1_origin", int'(origin), 5'b00001);
        check("t1_tclr",   int'(token_clear), 1);

        // Confirm with cycle-accurate timing, ready high before valid.
        do_reset();
        dl_in_vec    = 5'b01100;
        report_ready = 1'b1;
        push_expected(5'b01100);
        tick();
        check("t2_origin", int'(origin), 5'b00100);
        check("t2_tclr1",  int'(token_clear), 1);
        check("t2_det0",   int'(dl_detect_out), 0);
        tick();
        check("t2_tclr2",  int'(token_clear), 1);
        tick();
        check("t2_tclr3",  int'(token_clear), 0);
        repeat (3) tick();
        check("t2_det_early", int'(dl_detect_out), 0);
        check("t2_val_early", int'(report_valid), 0);
        tick();
        check("t2_det", int'(dl_detect_out), 1);
        check("t2_val", int'(report_valid), 1);
        collect(10, 16'hFFFF);
        check_halt(5'b00100);

        // Abort when the origin drops on the second ARM cycle.
        do_reset();
        dl_in_vec = 5'b00010;
        repeat (4) tick();
        check("t3_origin", int'(origin), 5'b00010);
        check("t3_tclr_arm", int'(token_clear), 0);
        dl_in_vec = '0;
        tick();
        check("t3_abort_origin", int'(origin), 0);
        check("t3_abort_tclr",   int'(token_clear), 1);
        check("t3_abort_det",    int'(dl_detect_out), 0);
        tick();
        check("t3_idle_tclr", int'(token_clear), 0);
        check("t3_idle_det",  int'(dl_detect_out), 0);
        check("t3_idle_orig", int'(origin), 0);
        dl_in_vec = 5'b00010;
        tick();
        check("t3_reelect", int'(origin), 5'b00010);
        check("t3_reelect_tclr", int'(token_clear), 1);

        // Backpressure on the report stream.
        do_reset();
        dl_in_vec = 5'b10001;
        push_expected(5'b10001);
        wait_valid(20);
        collect(20, 16'hFFE4);
        check_halt(5'b00001);

        // Asynchronous reset in the middle of a report, then a full re-run.
        do_reset();
        dl_in_vec = 5'b00011;
        wait_valid(20);
        #2;
        reset = 1'b0;
        #1;
        check_quiet("t5_async");
        exp_q.delete();
        tick();
        reset = 1'b1;
        push_expected(5'b00011);
        wait_valid(20);
        collect(10, 16'hFFFF);
        check_halt(5'b00001);

        // Two requests arriving together: lowest index wins.
        do_reset();
        dl_in_vec = 5'b10010;
        tick();
        check("t6_origin", int'(origin), 5'b00010);
        push_expected(5'b10010);
        wait_valid(20);
        check("t6_origin_rpt", int'(origin), 5'b00010);
        collect(10, 16'hFFFF);
        check_halt(5'b00010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
